reset_sequencer: RTL and testbench

Parametrised reset controller; the next generation of the single-channel two-flop reset synchronizer. Synchronizes deassertion of the async board reset (assertion stays asynchronous), stretches the reset to a minimum width, then releases N_CH reset channels one at a time with a fixed gap. Adds a synchronous soft-reset request and a rst_done status output. Sits at the top level and feeds rst_n to the sensor, controller and PWM blocks in release order.

---
 rtl/reset_sequencer_pkg.sv | 16 +
 rtl/reset_sequencer_synch_chain.sv | 34 +++
 rtl/reset_sequencer.sv | 110 +++++++++++
 tb/tb_reset_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and a small
// constant helper used to size the sequencer's counter.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        S_HOLD,
        S_STRETCH,
        S_RELEASE,
        S_DONE
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer_synch_chain.sv
// Generic reset synchronizer: assertion is asynchronous, deassertion is
// shifted through SYNC_STAGES flops on the selected clock edge.
module reset_synch_chain #(
    parameter int SYNC_STAGES = 2,
    parameter bit NEG_EDGE    = 1'b1
) (
    input  logic clk,
    input  logic RST_n,
    output logic sync_ok
);

    logic                   clk_act;
    logic [SYNC_STAGES-1:0] sync_q;

    // A single flop process serves both edge polarities via a local clock.
    generate
        if (NEG_EDGE) begin : g_neg
            assign clk_act = ~clk;
        end else begin : g_pos
            assign clk_act = clk;
        end
    endgenerate

    always_ff @(posedge clk_act or negedge RST_n) begin
        if (!RST_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_ok = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Top-level reset controller: synchronizes the board reset, stretches it,
// then releases N_CH active-low reset channels one at a time.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit NEG_EDGE    = 1'b1,
    parameter int N_CH        = 3,
    parameter int STRETCH     = 16,
    parameter int GAP         = 8
) (
    input  logic            clk,
    input  logic            RST_n,
    input  logic            soft_rst_req,
    output logic [N_CH-1:0] rst_n,
    output logic            rst_done
);

    localparam int CNT_W = $clog2(max_int(STRETCH, GAP) + 1);
    localparam int CH_W  = $clog2(N_CH) + 1;

    logic             clk_act;
    logic             sync_ok;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CH_W-1:0]  ch_q;
    logic [CH_W-1:0]  ch_next;
    logic [N_CH-1:0]  rst_n_q;
    logic             rst_done_q;

    generate
        if (NEG_EDGE) begin : g_neg
            assign clk_act = ~clk;
        end else begin : g_pos
            assign clk_act = clk;
        end
    endgenerate

    reset_synch_chain #(
        .SYNC_STAGES(SYNC_STAGES),
        .NEG_EDGE   (NEG_EDGE)
    ) u_sync (
        .clk    (clk),
        .RST_n  (RST_n),
        .sync_ok(sync_ok)
    );

    assign ch_next = ch_q + CH_W'(1);

    // Soft reset outranks normal sequencing everywhere except HOLD, so a held
    // request pins the stretch counter at zero until it drops.
    always_ff @(posedge clk_act or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= S_HOLD;
            cnt_q      <= '0;
            ch_q       <= '0;
            rst_n_q    <= '0;
            rst_done_q <= 1'b0;
        end else if (soft_rst_req && (state_q != S_HOLD)) begin
            state_q    <= S_STRETCH;
            cnt_q      <= '0;
            ch_q       <= '0;
            rst_n_q    <= '0;
            rst_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (sync_ok) begin
                        state_q <= S_STRETCH;
                        cnt_q   <= '0;
                    end
                end
                S_STRETCH: begin
                    if (cnt_q == CNT_W'(STRETCH - 1)) begin
                        rst_n_q[0] <= 1'b1;
                        ch_q       <= '0;
                        cnt_q      <= '0;
                        if (N_CH == 1) begin
                            state_q    <= S_DONE;
                            rst_done_q <= 1'b1;
                        end else begin
                            state_q <= S_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (cnt_q == CNT_W'(GAP - 1)) begin
                        rst_n_q <= rst_n_q | (N_CH'(1) << ch_next);
                        ch_q    <= ch_next;
                        cnt_q   <= '0;
                        if (ch_next == CH_W'(N_CH - 1)) begin
                            state_q    <= S_DONE;
                            rst_done_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rst_n    = rst_n_q;
    assign rst_done = rst_done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: power-on table, soft-reset and
// glitch sequences, randomized traffic against an edge-count model.
module tb_reset_sequencer;

    localparam int S   = 2;
    localparam int STR = 16;
    localparam int GP  = 8;
    localparam int NC  = 3;

    typedef struct {
        int            edgeNum;
        logic [NC-1:0] expRst;
        logic          expDone;
    } vec_t;

    logic          clk;
    logic          rstN;
    logic          softReq;
    logic [NC-1:0] rstNOut;
    logic          rstDone;
    logic          rstN2;
    logic          softReq2;
    logic [0:0]    rstNOut2;
    logic          rstDone2;

    int   checks    = 0;
    int   passes    = 0;
    int   fails     = 0;
    int   edgeN     = 0;
    int   anchor    = S + 1;
    int   burstLeft = 0;
    vec_t powerTable[6];

    reset_sequencer #(
        .SYNC_STAGES(S), .NEG_EDGE(1'b1), .N_CH(NC), .STRETCH(STR), .GAP(GP)
    ) dut (
        .clk(clk), .RST_n(rstN), .soft_rst_req(softReq),
        .rst_n(rstNOut), .rst_done(rstDone)
    );

    reset_sequencer #(
        .SYNC_STAGES(3), .NEG_EDGE(1'b0), .N_CH(1), .STRETCH(1), .GAP(1)
    ) dut2 (
        .clk(clk), .RST_n(rstN2), .soft_rst_req(softReq2),
        .rst_n(rstNOut2), .rst_done(rstDone2)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Channel i is released STR + i*GP edges after the last edge that
    // (re)started the stretch; edgeN counts edges since RST_n last rose.
    function automatic logic [NC-1:0] modelRst();
        logic [NC-1:0] e;
        for (int i = 0; i < NC; i++) e[i] = (edgeN >= anchor + STR + i * GP);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    task automatic checkNow(input string name, input logic [NC-1:0] er, input logic ed);
        checkOutput({name, "_rst_n"}, 32'(rstNOut), 32'(er));
        checkOutput({name, "_done"}, 32'(rstDone), 32'(ed));
    endtask

    task automatic resetModel();
        edgeN  = 0;
        anchor = S + 1;
    endtask

    task automatic applyStimulus(input logic rstVal, input logic req);
        @(posedge clk);
        #1;
        rstN    = rstVal;
        softReq = req;
        @(negedge clk);
        if (!rstN) begin
            resetModel();
        end else begin
            edgeN++;
            if (req && edgeN >= S + 2) anchor = edgeN;
        end
        #1;
        checkOutput("model_rst_n", 32'(rstNOut), 32'(modelRst()));
        checkOutput("model_done", 32'(rstDone), 32'(&modelRst()));
    endtask

    task automatic runFor(input int n);
        repeat (n) applyStimulus(1'b1, 1'b0);
    endtask

    task automatic glitchNow(input string name);
        rstN = 1'b0;
        resetModel();
        #1;
        checkNow(name, '0, 1'b0);
        #1;
        rstN = 1'b1;
    endtask

    task automatic powerOnRun(input logic reqInHold, input string tag);
        for (int n = 1; n <= 35; n++) begin
            applyStimulus(1'b1, reqInHold && (n <= S + 1));
            for (int v = 0; v < 6; v++) begin
                if (powerTable[v].edgeNum == n) begin
                    checkOutput({tag, "_rst_n"}, 32'(rstNOut), 32'(powerTable[v].expRst));
                    checkOutput({tag, "_done"}, 32'(rstDone), 32'(powerTable[v].expDone));
                end
            end
        end
    endtask

    initial begin
        rstN     = 1'b0;
        softReq  = 1'b0;
        rstN2    = 1'b0;
        softReq2 = 1'b0;
        powerTable[0] = '{18, 3'b000, 1'b0};
        powerTable[1] = '{19, 3'b001, 1'b0};
        powerTable[2] = '{26, 3'b001, 1'b0};
        powerTable[3] = '{27, 3'b011, 1'b0};
        powerTable[4] = '{34, 3'b011, 1'b0};
        powerTable[5] = '{35, 3'b111, 1'b1};

        #1;
        checkNow("async_reset", '0, 1'b0);
        checkOutput("nch1_reset", 32'({rstNOut2, rstDone2}), 32'(0));
        repeat (5) applyStimulus(1'b0, 1'b0);

        // Power-on, with a soft request during HOLD that must be ignored.
        powerOnRun(1'b1, "poweron");

        // Single-cycle soft reset from DONE.
        applyStimulus(1'b1, 1'b1);
        checkNow("soft_k", 3'b000, 1'b0);
        runFor(15);
        checkNow("soft_k15", 3'b000, 1'b0);
        runFor(1);
        checkNow("soft_k16", 3'b001, 1'b0);
        runFor(7);
        checkNow("soft_k23", 3'b001, 1'b0);
        runFor(1);
        checkNow("soft_k24", 3'b011, 1'b0);
        runFor(7);
        checkNow("soft_k31", 3'b011, 1'b0);
        runFor(1);
        checkNow("soft_k32", 3'b111, 1'b1);

        // Soft reset held for ten edges.
        repeat (10) applyStimulus(1'b1, 1'b1);
        runFor(15);
        checkNow("held_k24", 3'b000, 1'b0);
        runFor(1);
        checkNow("held_k25", 3'b001, 1'b0);

        // Short RST_n glitch while two channels are out of reset.
        runFor(8);
        checkNow("pre_glitch", 3'b011, 1'b0);
        glitchNow("glitch_clear");
        runFor(34);
        checkNow("glitch_e34", 3'b011, 1'b0);
        runFor(1);
        checkNow("glitch_e35", 3'b111, 1'b1);

        // RST_n dropped mid-cycle between edges 30 and 31, then restarted.
        repeat (2) applyStimulus(1'b0, 1'b0);
        runFor(30);
        checkNow("pre_drop", 3'b011, 1'b0);
        #2;
        rstN = 1'b0;
        resetModel();
        #1;
        checkNow("drop_clear", 3'b000, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0);
        powerOnRun(1'b0, "restart");

        for (int it = 0; it < 1500; it++) begin
            int  r;
            logic req;
            r = $urandom_range(0, 299);
            if (r == 0) begin
                glitchNow("rand_glitch");
            end else if (r < 3) begin
                applyStimulus(1'b0, 1'b0);
            end else begin
                if (burstLeft == 0 && $urandom_range(0, 59) == 0) burstLeft = $urandom_range(1, 12);
                req = (burstLeft > 0);
                if (burstLeft > 0) burstLeft--;
                applyStimulus(1'b1, req);
            end
        end

        // Posedge variant with a single channel and minimum stretch.
        @(negedge clk);
        #1;
        rstN2 = 1'b1;
        for (int p = 1; p <= 5; p++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("nch1_pos%0d", p), 32'({rstNOut2, rstDone2}), (p >= 5) ? 32'd3 : 32'd0);
            @(negedge clk);
            #1;
            checkOutput($sformatf("nch1_neg%0d", p), 32'({rstNOut2, rstDone2}), (p >= 5) ? 32'd3 : 32'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
